// File: rtl/gate_checker_pkg.sv
// Shared encodings and truth tables for the gate truth checker.
// State codes are 3-bit; tables are indexed by the stimulus vector.
package gate_checker_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_DRIVE  = 3'd1;
  localparam state_t S_SETTLE = 3'd2;
  localparam state_t S_CHECK  = 3'd3;
  localparam state_t S_DONE   = 3'd4;

  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/settle_timer.sv
// Load/enable up-counter that flags the last settle cycle.
// expired is high while the count sits at CYCLES-1.
module settle_timer
  import gate_checker_pkg::*;
#(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = (cnt == W'(CYCLES - 1));

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps every input vector of a gate, compares its output
// against TRUTH_TABLE, and reports error count and first failure.
module gate_truth_checker
  import gate_checker_pkg::*;
#(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter logic [2**N_IN-1:0] TRUTH_TABLE = TT_AND2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] fail_idx
);

  localparam logic [N_IN-1:0] LAST = '1;

  state_t          state;
  logic [N_IN-1:0] idx;
  logic            first_err;
  logic            expired;
  logic            mismatch;
  logic [N_IN:0]   err_nxt;

  assign mismatch = (dut_y != TRUTH_TABLE[idx]);
  assign err_nxt  = err_count + {{N_IN{1'b0}}, mismatch};

  settle_timer #(
    .CYCLES (SETTLE_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (state == S_DRIVE),
    .en      (state == S_SETTLE),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      stim      <= '0;
      idx       <= '0;
      first_err <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_idx  <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_DRIVE;
            idx       <= '0;
            first_err <= 1'b0;
            err_count <= '0;
            fail_idx  <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end
        S_DRIVE: begin
          stim  <= idx;
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (expired) state <= S_CHECK;
        end
        S_CHECK: begin
          err_count <= err_nxt;
          if (mismatch && !first_err) begin
            fail_idx  <= idx;
            first_err <= 1'b1;
          end
          // Compare the last vector before deciding; idx never wraps.
          if (idx == LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end else begin
            idx   <= idx + N_IN'(1);
            state <= S_DRIVE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed sweeps of two checker instances (AND and XOR tables)
// with a scoreboard of expected sweep results.
module tb_gate_truth_checker;
  import gate_checker_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_x;
  logic [1:0] stim_a, stim_x;
  logic       y_a, y_x;
  logic       busy_a, done_a, pass_a;
  logic       busy_x, done_x, pass_x;
  logic [2:0] err_a, err_x;
  logic [1:0] fidx_a, fidx_x;

  int mode_a = 0;
  int mode_x = 3;
  int sel    = 0;
  int total  = 0;
  int bad    = 0;

  typedef struct {
    logic       p;
    logic [2:0] e;
    logic [1:0] f;
  } exp_t;

  exp_t sbq[$];

  logic       m_busy, m_done, m_pass;
  logic [2:0] m_err;
  logic [1:0] m_fidx, m_stim;

  // modes: 0 AND, 1 stuck-at-0, 2 stuck-at-1, 3 XOR
  function automatic logic gate(int m, logic [1:0] v);
    case (m)
      0:       return v[1] & v[0];
      1:       return 1'b0;
      2:       return 1'b1;
      default: return v[1] ^ v[0];
    endcase
  endfunction

  always_comb y_a = gate(mode_a, stim_a);
  always_comb y_x = gate(mode_x, stim_x);

  always_comb begin
    m_busy = (sel == 0) ? busy_a : busy_x;
    m_done = (sel == 0) ? done_a : done_x;
    m_pass = (sel == 0) ? pass_a : pass_x;
    m_err  = (sel == 0) ? err_a  : err_x;
    m_fidx = (sel == 0) ? fidx_a : fidx_x;
    m_stim = (sel == 0) ? stim_a : stim_x;
  end

  gate_truth_checker u_and (
    .clk       (clk),
    .rst       (rst),
    .start     (start_a),
    .stim      (stim_a),
    .dut_y     (y_a),
    .busy      (busy_a),
    .done      (done_a),
    .pass      (pass_a),
    .err_count (err_a),
    .fail_idx  (fidx_a)
  );

  gate_truth_checker #(
    .N_IN          (2),
    .SETTLE_CYCLES (4),
    .TRUTH_TABLE   (TT_XOR2)
  ) u_xor (
    .clk       (clk),
    .rst       (rst),
    .start     (start_x),
    .stim      (stim_x),
    .dut_y     (y_x),
    .busy      (busy_x),
    .done      (done_x),
    .pass      (pass_x),
    .err_count (err_x),
    .fail_idx  (fidx_x)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_stim"}, 32'(m_stim), 0);
    chk({tag, "_busy"}, 32'(m_busy), 0);
    chk({tag, "_done"}, 32'(m_done), 0);
    chk({tag, "_pass"}, 32'(m_pass), 0);
    chk({tag, "_err"},  32'(m_err),  0);
    chk({tag, "_fidx"}, 32'(m_fidx), 0);
  endtask

  task automatic set_start(int s, logic v);
    if (s == 0) start_a = v;
    else        start_x = v;
  endtask

  task automatic sweep(string tag, int s, int mode, logic [3:0] tt,
                       bit repulse, int abort_at);
    exp_t e;
    exp_t got_e;
    bit   first;
    bit   got;
    sel = s;
    if (s == 0) mode_a = mode;
    else        mode_x = mode;
    e.e   = '0;
    e.f   = '0;
    first = 1'b0;
    for (int v = 0; v < 4; v++) begin
      if (gate(mode, v[1:0]) !== tt[v]) begin
        e.e++;
        if (!first) begin
          e.f   = v[1:0];
          first = 1'b1;
        end
      end
    end
    e.p = (e.e == 0);
    sbq.push_back(e);
    set_start(s, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(s, 1'b0);
    got = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      @(negedge clk);
      set_start(s, 1'b0);
      if (c == 1) begin
        chk({tag, "_busy1"}, 32'(m_busy), 1);
        chk({tag, "_done1"}, 32'(m_done), 0);
      end
      if (repulse && (c == 5 || c == 12)) set_start(s, 1'b1);
      if (c == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_reset({tag, "_abort"});
        void'(sbq.pop_front());
        got = 1'b1;
        break;
      end
      if (c % 6 == 3) chk({tag, "_stim"}, 32'(m_stim), 32'(c / 6));
      if (m_done) begin
        chk({tag, "_len"}, 32'(c), 24);
        got_e = sbq.pop_front();
        chk({tag, "_pass"}, 32'(m_pass), 32'(got_e.p));
        chk({tag, "_err"},  32'(m_err),  32'(got_e.e));
        chk({tag, "_fidx"}, 32'(m_fidx), 32'(got_e.f));
        got = 1'b1;
        break;
      end
    end
    if (!got) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    rst     = 1'b1;
    start_a = 1'b0;
    start_x = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sel = 0;
    #1 chk_reset("rst_a");
    sel = 1;
    #1 chk_reset("rst_x");
    sweep("t1_and",     0, 0, TT_AND2, 1'b0, 0);
    sweep("t2_stuck0",  0, 1, TT_AND2, 1'b0, 0);
    sweep("t3_stuck1",  0, 2, TT_AND2, 1'b0, 0);
    sweep("t1_redo",    0, 0, TT_AND2, 1'b0, 0);
    sweep("t4_xor",     1, 3, TT_XOR2, 1'b0, 0);
    sweep("t4_and_xtt", 1, 0, TT_XOR2, 1'b0, 0);
    sweep("t5_repulse", 0, 0, TT_AND2, 1'b1, 0);
    sweep("t6_abort",   0, 2, TT_AND2, 1'b0, 10);
    sweep("t6_fresh",   0, 1, TT_AND2, 1'b0, 0);
    sweep("t6_restart", 0, 0, TT_AND2, 1'b0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
